// File: rtl/vec_mag_path_acc_if.sv
// AXI-Stream bundle used on both sides of the path accumulator.
interface vec_mag_path_acc_if #(
  parameter int unsigned DataWidth = 32
);
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic                 tuser;
  logic                 tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/vec_mag_path_acc.sv
// Per-frame path statistics over a magnitude stream: saturating sum and beat count, plus
// max magnitude, emitted as one packed result beat per frame through a single output register.
module vec_mag_path_acc #(
  parameter int unsigned COORD_WIDTH = 8,
  parameter int unsigned SUM_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  vec_mag_path_acc_if.slave          s_axis,
  vec_mag_path_acc_if.master         m_axis,
  output logic [31:0]                frames_o
);

  localparam int unsigned OutWidth = SUM_WIDTH + CNT_WIDTH + COORD_WIDTH;

  logic [SUM_WIDTH-1:0]   acc_sum_q;
  logic [CNT_WIDTH-1:0]   acc_cnt_q;
  logic [COORD_WIDTH-1:0] acc_max_q;
  logic                   acc_sat_q;
  logic [OutWidth-1:0]    out_data_q;
  logic                   out_user_q;
  logic                   out_valid_q;
  logic [31:0]            frames_q;

  logic [COORD_WIDTH-1:0] mag;
  logic [SUM_WIDTH:0]     sum_wide;
  logic                   sum_sat;
  logic                   cnt_sat;
  logic [SUM_WIDTH-1:0]   nsum;
  logic [CNT_WIDTH-1:0]   ncnt;
  logic [COORD_WIDTH-1:0] nmax;
  logic                   nsat;
  logic                   in_accept;
  logic                   out_accept;

  // Only the low magnitude field of the input beat carries information.
  logic unused_in;
  assign unused_in = ^{s_axis.tdata, s_axis.tuser};

  assign mag        = s_axis.tdata[COORD_WIDTH-1:0];
  assign s_axis.tready = !rst && (!out_valid_q || m_axis.tready);
  assign in_accept  = s_axis.tvalid && s_axis.tready;
  assign out_accept = out_valid_q && m_axis.tready;

  always_comb begin
    sum_wide = {1'b0, acc_sum_q} + (SUM_WIDTH + 1)'(mag);
    sum_sat  = sum_wide[SUM_WIDTH];
    nsum     = sum_sat ? {SUM_WIDTH{1'b1}} : sum_wide[SUM_WIDTH-1:0];
    cnt_sat  = &acc_cnt_q;
    ncnt     = cnt_sat ? acc_cnt_q : acc_cnt_q + CNT_WIDTH'(1);
    nmax     = (mag > acc_max_q) ? mag : acc_max_q;
    nsat     = acc_sat_q | sum_sat | cnt_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sum_q   <= '0;
      acc_cnt_q   <= '0;
      acc_max_q   <= '0;
      acc_sat_q   <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frames_q    <= '0;
    end else begin
      if (in_accept && s_axis.tlast) begin
        out_data_q  <= {nmax, ncnt, nsum};
        out_user_q  <= nsat;
        out_valid_q <= 1'b1;
        acc_sum_q   <= '0;
        acc_cnt_q   <= '0;
        acc_max_q   <= '0;
        acc_sat_q   <= 1'b0;
      end else begin
        if (out_accept) begin
          out_valid_q <= 1'b0;
        end
        if (in_accept) begin
          acc_sum_q <= nsum;
          acc_cnt_q <= ncnt;
          acc_max_q <= nmax;
          acc_sat_q <= nsat;
        end
      end
      if (out_accept) begin
        frames_q <= frames_q + 32'd1;
      end
    end
  end

  assign m_axis.tdata  = out_data_q;
  assign m_axis.tuser  = out_user_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_valid_q;
  assign frames_o      = frames_q;

endmodule

// File: tb/tb_vec_mag_path_acc.sv
// Self-checking bench for vec_mag_path_acc: table vectors, corner sequences, randomized frames.
module tb_vec_mag_path_acc;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 16;
  localparam int unsigned NW = 8;
  localparam int unsigned OW = SW + NW + CW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] frames;

  vec_mag_path_acc_if #(.DataWidth(4 * CW)) s_if ();
  vec_mag_path_acc_if #(.DataWidth(OW))     m_if ();

  always #5 clk = ~clk;

  vec_mag_path_acc #(
    .COORD_WIDTH(CW),
    .SUM_WIDTH  (SW),
    .CNT_WIDTH  (NW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .frames_o(frames)
  );

  typedef struct {
    int unsigned sum;
    int unsigned cnt;
    int unsigned max;
    bit          sat;
  } res_t;

  typedef struct {
    int unsigned n;
    int unsigned mags[4];
    res_t        exp;
  } vec_t;

  res_t        exp_q[$];
  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned frames_exp = 0;
  bit          held_v = 1'b0;
  logic [OW-1:0] held_d;
  logic        held_u;
  bit          rand_bp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame statistics straight from the arithmetic definition.
  function automatic res_t model(input int unsigned mags[$]);
    res_t        r;
    longint      total = 0;
    int unsigned mx = 0;
    foreach (mags[i]) begin
      total += mags[i];
      if (mags[i] > mx) mx = mags[i];
    end
    r.sum = (total > 65535) ? 65535 : int'(total);
    r.cnt = (mags.size() > 255) ? 255 : mags.size();
    r.max = mx;
    r.sat = (total > 65535) || (mags.size() > 255);
    return r;
  endfunction

  function automatic void add_vec(input int unsigned n, input int unsigned a, input int unsigned b,
                                  input int unsigned c, input int unsigned d,
                                  input int unsigned sum, input int unsigned cnt,
                                  input int unsigned max, input bit sat);
    vec_t v;
    v.n = n;
    v.mags[0] = a; v.mags[1] = b; v.mags[2] = c; v.mags[3] = d;
    v.exp.sum = sum; v.exp.cnt = cnt; v.exp.max = max; v.exp.sat = sat;
    vecs.push_back(v);
  endfunction

  // Output monitor: result scoreboard, hold stability, stall ready, frames_o tracking.
  always @(negedge clk) begin
    res_t e;
    chk("frames_o", frames, frames_exp);
    if (rst) begin
      frames_exp = 0;
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", m_if.tvalid, 1);
        chk("hold_data", m_if.tdata, held_d);
        chk("hold_user", m_if.tuser, held_u);
      end
      if (m_if.tvalid && !m_if.tready) begin
        chk("stall_s_tready", s_if.tready, 0);
        held_v = 1'b1;
        held_d = m_if.tdata;
        held_u = m_if.tuser;
      end else begin
        held_v = 1'b0;
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0h expected none at %0t", m_if.tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("res_sum", m_if.tdata[SW-1:0], e.sum);
          chk("res_cnt", m_if.tdata[SW+NW-1:SW], e.cnt);
          chk("res_max", m_if.tdata[OW-1:SW+NW], e.max);
          chk("res_user", m_if.tuser, e.sat);
          chk("res_tlast", m_if.tlast, 1);
        end
        frames_exp++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 m_if.tready = 1'($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int unsigned mag, input bit last);
    logic [31:0] r;
    bit          acc;
    int          w = 0;
    r = $urandom();
    s_if.tdata  = {r[31:CW], mag[CW-1:0]};
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      w++;
    end while (!acc && w < 300);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no ready expected ready within 300 cycles");
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int unsigned mags[$];
    res_t        r;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;

    add_vec(3, 5, 8, 3, 0, 16, 3, 8, 0);
    add_vec(1, 255, 0, 0, 0, 255, 1, 255, 0);
    add_vec(2, 1, 2, 0, 0, 3, 2, 2, 0);
    add_vec(2, 0, 0, 0, 0, 0, 2, 0, 0);
    add_vec(4, 8, 8, 2, 8, 26, 4, 8, 0);
    add_vec(4, 200, 100, 250, 7, 557, 4, 250, 0);

    @(negedge clk);
    chk("rst_s_tready", s_if.tready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_m_tuser", m_if.tuser, 0);

    foreach (vecs[k]) begin
      exp_q.push_back(vecs[k].exp);
      for (int i = 0; i < int'(vecs[k].n); i++) begin
        send(vecs[k].mags[i], i == int'(vecs[k].n) - 1);
      end
      chk("latency_valid", m_if.tvalid, 1);
      drain();
      chk("tbl_frames_o", frames, k + 1);
    end

    // Long frame saturates both sum and count, then the next frame must be clean.
    exp_q.push_back('{sum: 65535, cnt: 255, max: 255, sat: 1'b1});
    for (int i = 0; i < 300; i++) send(255, i == 299);
    exp_q.push_back('{sum: 4, cnt: 1, max: 4, sat: 1'b0});
    send(4, 1);
    drain();

    // Backpressure: A held while B is offered.
    do_reset();
    m_if.tready = 1'b0;
    exp_q.push_back('{sum: 10, cnt: 1, max: 10, sat: 1'b0});
    exp_q.push_back('{sum: 50, cnt: 2, max: 30, sat: 1'b0});
    send(10, 1);
    fork
      begin
        send(20, 0);
        send(30, 1);
      end
      begin
        repeat (6) @(posedge clk);
        #1 m_if.tready = 1'b1;
      end
    join
    drain();
    chk("bp_frames_o", frames, 2);

    // Reset mid-frame discards the partial accumulation.
    send(9, 0);
    send(9, 0);
    do_reset();
    chk("rst_mid_frames_o", frames, 0);
    exp_q.push_back('{sum: 7, cnt: 1, max: 7, sat: 1'b0});
    send(7, 1);
    drain();
    chk("rst_mid_frames_after", frames, 1);

    // Back-to-back single-beat frames with no bubbles.
    do_reset();
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back('{sum: i, cnt: 1, max: i, sat: 1'b0});
      s_if.tdata = 32'(i);
      @(negedge clk);
      chk("b2b_s_tready", s_if.tready, 1);
      if (i > 1) chk("b2b_m_tvalid", m_if.tvalid, 1);
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    @(negedge clk);
    chk("b2b_m_tvalid_last", m_if.tvalid, 1);
    drain();
    chk("b2b_frames_o", frames, 4);

    // Randomized frames under random backpressure.
    rand_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int unsigned len;
      bit          big;
      big = (f % 10) == 9;
      len = big ? $urandom_range(250, 270) : $urandom_range(1, 6);
      mags.delete();
      for (int i = 0; i < int'(len); i++) begin
        mags.push_back(big ? $urandom_range(200, 255) : $urandom_range(0, 255));
      end
      r = model(mags);
      exp_q.push_back(r);
      foreach (mags[i]) send(mags[i], i == mags.size() - 1);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2 m_if.tready = 1'b1;
    drain();
    chk("rand_frames_o", frames, 44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
